// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

  localparam int          PC_WIDTH    = 32;
  localparam logic [31:0] NOP_BUBBLE  = 32'h0;
  localparam int          INSTR_BYTES = 4;

  typedef struct packed {
    logic                allocated;
    logic                filled;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order ring of fetch slots: allocate on grant, fill on response, pop at head.
// Head is presented combinationally; a flush clears all slots and pointers in one cycle.
module fetch_slot_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [WIDTH-1:0] alloc_pc_i,
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
  input  logic             pop_i,
  output logic             head_vld_o,
  output logic [WIDTH-1:0] head_pc_o,
  output logic [31:0]      head_instr_o,
  output logic [CNT_W-1:0] alloc_cnt_o,
  output logic [CNT_W-1:0] unfilled_cnt_o
);

  fetch_slot_t      slot_q [DEPTH];
  fetch_slot_t      slot_d [DEPTH];
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [CNT_W-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0] unfilled_cnt_q, unfilled_cnt_d;
  fetch_slot_t      head_slot;

  // Pop, fill and allocate always touch distinct slots, so their order here is irrelevant.
  always_comb begin
    slot_d         = slot_q;
    alloc_ptr_d    = alloc_ptr_q;
    fill_ptr_d     = fill_ptr_q;
    head_ptr_d     = head_ptr_q;
    alloc_cnt_d    = alloc_cnt_q;
    unfilled_cnt_d = unfilled_cnt_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
      alloc_ptr_d    = '0;
      fill_ptr_d     = '0;
      head_ptr_d     = '0;
      alloc_cnt_d    = '0;
      unfilled_cnt_d = '0;
    end else begin
      if (pop_i) begin
        slot_d[head_ptr_q].allocated = 1'b0;
        slot_d[head_ptr_q].filled    = 1'b0;
        head_ptr_d                   = head_ptr_q + 1'b1;
      end
      if (fill_i) begin
        slot_d[fill_ptr_q].filled = 1'b1;
        slot_d[fill_ptr_q].instr  = fill_data_i;
        fill_ptr_d                = fill_ptr_q + 1'b1;
      end
      if (alloc_i) begin
        slot_d[alloc_ptr_q] = '{allocated: 1'b1, filled: 1'b0,
                                pc: PC_WIDTH'(alloc_pc_i), instr: NOP_BUBBLE};
        alloc_ptr_d         = alloc_ptr_q + 1'b1;
      end
      alloc_cnt_d    = alloc_cnt_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      unfilled_cnt_d = unfilled_cnt_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      alloc_ptr_q    <= '0;
      fill_ptr_q     <= '0;
      head_ptr_q     <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
    end else begin
      slot_q         <= slot_d;
      alloc_ptr_q    <= alloc_ptr_d;
      fill_ptr_q     <= fill_ptr_d;
      head_ptr_q     <= head_ptr_d;
      alloc_cnt_q    <= alloc_cnt_d;
      unfilled_cnt_q <= unfilled_cnt_d;
    end
  end

  assign head_slot      = slot_q[head_ptr_q];
  assign head_vld_o     = head_slot.allocated && head_slot.filled;
  assign head_pc_o      = head_vld_o ? WIDTH'(head_slot.pc) : '0;
  assign head_instr_o   = head_vld_o ? head_slot.instr : NOP_BUBBLE;
  assign alloc_cnt_o    = alloc_cnt_q;
  assign unfilled_cnt_o = unfilled_cnt_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: sequential PC generation, req/gnt issue, in-order response buffering to IF/ID.
// First instruction two cycles after reset with a 1-cycle memory; stall holds the head, redirect flushes.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [WIDTH-1:0] IF_Pc,
  output logic [31:0]      IF_Instruction,
  output logic             IF_Valid,
  output logic             rsp_error
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DCNT_W = CNT_W + 3;

  logic [WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [DCNT_W-1:0] discard_q, discard_d;
  logic              rsp_error_q, rsp_error_d;
  logic [CNT_W-1:0]  alloc_cnt, unfilled_cnt;
  logic [DCNT_W-1:0] flush_backlog;
  logic              grant, rsp_drop, rsp_fill, rsp_stray, pop;

  assign imem_req  = reset && !redirect && (alloc_cnt < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // Stale responses from before a redirect are drained ahead of any live ones.
  assign rsp_drop  = imem_rvalid && (discard_q != '0);
  assign rsp_fill  = imem_rvalid && (discard_q == '0) && (unfilled_cnt != '0);
  assign rsp_stray = imem_rvalid && (discard_q == '0) && (unfilled_cnt == '0);
  assign pop       = IF_Valid && !stall && !redirect;

  assign flush_backlog = discard_q + DCNT_W'(unfilled_cnt);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    discard_d   = discard_q;
    rsp_error_d = rsp_error_q || rsp_stray;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      discard_d  = flush_backlog;
      if (imem_rvalid && (flush_backlog != '0)) discard_d = flush_backlog - 1'b1;
    end else begin
      if (grant)    fetch_pc_d = fetch_pc_q + WIDTH'(INSTR_BYTES);
      if (rsp_drop) discard_d  = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q  <= RESET_PC;
      discard_q   <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      discard_q   <= discard_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign rsp_error = rsp_error_q;

  fetch_slot_queue #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_slot_queue (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (redirect),
    .alloc_i       (grant),
    .alloc_pc_i    (fetch_pc_q),
    .fill_i        (rsp_fill),
    .fill_data_i   (imem_rdata),
    .pop_i         (pop),
    .head_vld_o    (IF_Valid),
    .head_pc_o     (IF_Pc),
    .head_instr_o  (IF_Instruction),
    .alloc_cnt_o   (alloc_cnt),
    .unfilled_cnt_o(unfilled_cnt)
  );

endmodule
